// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-frame shadow latch, leading-zero
// suppression, 16-level brightness PWM and an all-off guard at each slot start.
module smg_scan_driver #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DIGITS         = 3,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  SYS_CLK,
    input  logic                  RESET_N,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic                  frame_start,
    output logic [7:0]            SMG_SEG,
    output logic [DIGITS-1:0]     SMG_DIG
);

    localparam int SLOT  = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int PRE_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLOT - 1);
    localparam logic [PRE_W-1:0] PRE_PEN   = PRE_W'(SLOT - 2);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    generate
        if (SLOT < GUARD + 2) begin : g_slot_check
            $error("smg_scan_driver: SLOT=%0d is shorter than GUARD+2=%0d", SLOT, GUARD + 2);
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_digit_check
            $error("smg_scan_driver: DIGITS=%0d outside 1..8", DIGITS);
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [PRE_W-1:0]    pre_r;
    logic [IDX_W-1:0]    idx_r;
    logic [3:0]          pwm_r;
    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   blank_r;
    logic                lz_en_r;
    logic [3:0]          bright_r;

    logic                pre_last_s;
    logic                idx_last_s;
    logic                latch_s;
    logic [3:0]          nib_s;
    logic                all_zero_s;
    logic [DIGITS-1:0]   lz_dark_s;
    logic                dark_s;
    logic [7:0]          seg_s;
    logic [DIGITS-1:0]   dig_s;

    assign pre_last_s = (pre_r == PRE_LAST);
    assign idx_last_s = (idx_r == IDX_LAST);
    assign latch_s    = pre_last_s & idx_last_s;

    // Slot prescaler, digit index and free-running PWM phase.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_r <= '0;
            idx_r <= '0;
            pwm_r <= 4'd0;
        end else begin
            pwm_r <= pwm_r + 4'd1;
            if (pre_last_s) begin
                pre_r <= '0;
                if (idx_last_s) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end
    end

    // Frame shadow: blank resets to all ones so the first frame stays dark.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            value_r  <= '0;
            dp_r     <= '0;
            blank_r  <= '1;
            lz_en_r  <= 1'b0;
            bright_r <= 4'd0;
        end else if (latch_s) begin
            value_r  <= value;
            dp_r     <= dp;
            blank_r  <= blank;
            lz_en_r  <= lz_en;
            bright_r <= bright;
        end
    end

    // Registered one cycle ahead so the pulse coincides with the latch cycle.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (pre_r == PRE_PEN) && idx_last_s;
        end
    end

    // Leading-zero mask: walk from the top digit while every nibble seen is zero.
    always_comb begin
        all_zero_s = 1'b1;
        lz_dark_s  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero_s   = all_zero_s & (value_r[4*i +: 4] == 4'd0);
            lz_dark_s[i] = lz_en_r & all_zero_s;
        end
    end

    // Segment and digit-enable selection for the current slot.
    always_comb begin
        nib_s  = value_r[idx_r*4 +: 4];
        dark_s = blank_r[idx_r] | lz_dark_s[idx_r] | (bright_r == 4'd0);
        dig_s  = '0;
        if (dark_s) begin
            seg_s = 8'h00;
        end else begin
            seg_s = {dp_r[idx_r], seg7(nib_s)};
        end
        if ((pre_r >= PRE_GUARD) && !dark_s && ((bright_r == 4'hF) || (pwm_r < bright_r))) begin
            dig_s[idx_r] = 1'b1;
        end else begin
            dig_s = '0;
        end
    end

    // Output registers with polarity applied; reset drives everything inactive.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SMG_SEG <= {8{SEG_ACTIVE_LOW}};
            SMG_DIG <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            SMG_SEG <= seg_s ^ {8{SEG_ACTIVE_LOW}};
            SMG_DIG <= dig_s ^ {DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed bench for smg_scan_driver with SLOT=10, three digits, guard of two.
module tb_smg_scan_driver;

    logic        SYS_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [11:0] value   = 12'h0A5;
    logic [2:0]  dp      = 3'b000;
    logic [2:0]  blank   = 3'b000;
    logic        lz_en   = 1'b0;
    logic [3:0]  bright  = 4'd15;
    logic        frame_start;
    logic [7:0]  SMG_SEG;
    logic [2:0]  SMG_DIG;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_seg [3];
    logic [2:0] exp_lit;
    logic [3:0] exp_br;

    smg_scan_driver #(
        .CLK_HZ(3000), .SCAN_HZ(100), .DIGITS(3), .GUARD(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .SYS_CLK(SYS_CLK), .RESET_N(RESET_N), .value(value), .dp(dp),
        .blank(blank), .lz_en(lz_en), .bright(bright),
        .frame_start(frame_start), .SMG_SEG(SMG_SEG), .SMG_DIG(SMG_DIG)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic set_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [2:0] lit, input logic [3:0] br);
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_lit    = lit;
        exp_br     = br;
    endtask

    // Outputs at cycle c reflect the counter state of cycle c-1.
    task automatic run(input int n);
        int st, pos, slot, pwm;
        logic on;
        logic [2:0] ed;
        for (int k = 0; k < n; k++) begin
            @(negedge SYS_CLK);
            cyc++;
            st   = cyc - 1;
            pos  = st % 10;
            slot = (st % 30) / 10;
            pwm  = st % 16;
            on   = exp_lit[slot] && (pos >= 2) && ((exp_br == 4'd15) || (pwm < int'(exp_br)));
            ed   = 3'b111;
            if (on) ed[slot] = 1'b0;
            check("dig", 32'(SMG_DIG), 32'(ed));
            check("seg", 32'(SMG_SEG), 32'(exp_seg[slot]));
            check("frame_start", 32'(frame_start), 32'((cyc % 30) == 29));
        end
    endtask

    initial begin
        repeat (3) @(negedge SYS_CLK);
        check("reset_dig", 32'(SMG_DIG), 32'h7);
        check("reset_seg", 32'(SMG_SEG), 32'hFF);
        check("reset_fs", 32'(frame_start), 32'h0);
        RESET_N = 1'b1;
        cyc = 0;

        set_frame(8'hFF, 8'hFF, 8'hFF, 3'b000, 4'd15);
        run(30);

        value = 12'h007; lz_en = 1'b1;
        set_frame(8'h92, 8'h88, 8'hC0, 3'b111, 4'd15);
        run(30);

        value = 12'h000; dp = 3'b001;
        set_frame(8'hF8, 8'hFF, 8'hFF, 3'b001, 4'd15);
        run(30);

        value = 12'h007; lz_en = 1'b0; dp = 3'b000; bright = 4'd4;
        set_frame(8'h40, 8'hFF, 8'hFF, 3'b001, 4'd15);
        run(30);

        bright = 4'd0;
        set_frame(8'hF8, 8'hC0, 8'hC0, 3'b111, 4'd4);
        run(30);

        value = 12'h123; bright = 4'd15;
        set_frame(8'hFF, 8'hFF, 8'hFF, 3'b000, 4'd0);
        run(30);

        // Mid-frame input change must not show until the next frame.
        set_frame(8'hB0, 8'hA4, 8'hF9, 3'b111, 4'd15);
        run(15);
        value = 12'h456; blank = 3'b010;
        run(15);

        set_frame(8'h82, 8'hFF, 8'h99, 3'b101, 4'd15);
        run(5);
        RESET_N = 1'b0;
        #1;
        check("async_rst_dig", 32'(SMG_DIG), 32'h7);
        check("async_rst_seg", 32'(SMG_SEG), 32'hFF);
        check("async_rst_fs", 32'(frame_start), 32'h0);
        repeat (2) @(negedge SYS_CLK);
        check("hold_rst_dig", 32'(SMG_DIG), 32'h7);
        RESET_N = 1'b1;
        cyc = 0;

        set_frame(8'hFF, 8'hFF, 8'hFF, 3'b000, 4'd15);
        run(30);
        set_frame(8'h82, 8'hFF, 8'h99, 3'b101, 4'd15);
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
